// File: rtl/datapath_exec.sv
// Execution datapath driven cycle-by-cycle by an external controller.
//
// Holds an 8x16 register file, operand registers A/B, a one-bit shifter on B,
// a 4-function ALU, the result register C and the Z/N/V status flags.
// Register indices and immediates are decoded from the current instruction.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   instr             instruction word (Rn/Rd/Rm, ALUop, imm8, imm5 fields)
//   nsel              one-hot register index select {Rn, Rd, Rm}
//   vsel              one-hot write-back source {mdata, sximm8, PC, C}
//   mdata, PC         memory read data and program counter write-back sources
//   write             register file write enable
//   loada, loadb      operand register loads from the register file
//   shift             B shifter control (pass, LSL1, LSR1, ASR1)
//   asel, bsel        ALU operand selects (zero / sximm5)
//   loadc, loads      result register and status flag loads
//   datapath_out      contents of C
//   Z_out/N_out/V_out registered status flags
//   dbg_sel, dbg_data combinational debug read of the register file
module datapath_exec #(
  parameter int unsigned PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         instr,
  input  logic [2:0]          nsel,
  input  logic [3:0]          vsel,
  input  logic [15:0]         mdata,
  input  logic [PC_WIDTH-1:0] PC,
  input  logic                write,
  input  logic                loada,
  input  logic                loadb,
  input  logic [1:0]          shift,
  input  logic                asel,
  input  logic                bsel,
  input  logic                loadc,
  input  logic                loads,
  output logic [15:0]         datapath_out,
  output logic                Z_out,
  output logic                N_out,
  output logic                V_out,
  input  logic [2:0]          dbg_sel,
  output logic [15:0]         dbg_data
);

  typedef enum logic [1:0] {
    AluAdd = 2'b00,
    AluSub = 2'b01,
    AluAnd = 2'b10,
    AluNot = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ShPass = 2'b00,
    ShLsl1 = 2'b01,
    ShLsr1 = 2'b10,
    ShAsr1 = 2'b11
  } shift_op_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0] rf_q [8];
  logic [15:0] a_q, b_q, c_q;
  logic        z_q, n_q, v_q;

  // ---------------------------------------------------------------------------
  // Instruction field decode
  // ---------------------------------------------------------------------------
  logic [2:0]  rn, rd, rm;
  logic [15:0] sximm8, sximm5, pc_ext;
  alu_op_e     alu_op;
  logic        unused_instr;

  assign rn     = instr[10:8];
  assign rd     = instr[7:5];
  assign rm     = instr[2:0];
  assign alu_op = alu_op_e'(instr[12:11]);
  assign sximm8 = {{8{instr[7]}}, instr[7:0]};
  assign sximm5 = {{11{instr[4]}}, instr[4:0]};
  assign pc_ext = 16'(PC);
  // Opcode bits belong to the controller; nothing here depends on them.
  assign unused_instr = ^instr[15:13];

  // ---------------------------------------------------------------------------
  // Register index and write-back source
  // ---------------------------------------------------------------------------
  logic [2:0]  reg_idx;
  logic [15:0] wdata;
  logic        wr_en;

  // Any nsel pattern that is not one-hot reads R0 (and blocks writes below).
  always_comb begin
    reg_idx = 3'd0;
    case (nsel)
      3'b100:  reg_idx = rn;
      3'b010:  reg_idx = rd;
      3'b001:  reg_idx = rm;
      default: reg_idx = 3'd0;
    endcase
  end

  always_comb begin
    wdata = 16'h0000;
    case (vsel)
      4'b1000: wdata = mdata;
      4'b0100: wdata = sximm8;
      4'b0010: wdata = pc_ext;
      4'b0001: wdata = c_q;
      default: wdata = 16'h0000;
    endcase
  end

  // Malformed selects must never corrupt the register file.
  assign wr_en = write & $onehot(nsel) & $onehot(vsel);

  // ---------------------------------------------------------------------------
  // Shifter on B
  // ---------------------------------------------------------------------------
  logic [15:0] b_shifted;

  always_comb begin
    b_shifted = b_q;
    case (shift_op_e'(shift))
      ShPass: b_shifted = b_q;
      ShLsl1: b_shifted = {b_q[14:0], 1'b0};
      ShLsr1: b_shifted = {1'b0, b_q[15:1]};
      ShAsr1: b_shifted = {b_q[15], b_q[15:1]};
      default: b_shifted = b_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [15:0] ain, bin, alu_res;
  logic        alu_v;

  assign ain = asel ? 16'h0000 : a_q;
  assign bin = bsel ? sximm5 : b_shifted;

  always_comb begin
    alu_res = 16'h0000;
    alu_v   = 1'b0;
    case (alu_op)
      AluAdd: begin
        alu_res = ain + bin;
        // Same-signed operands giving an opposite-signed sum.
        alu_v   = (ain[15] == bin[15]) && (alu_res[15] != ain[15]);
      end
      AluSub: begin
        alu_res = ain - bin;
        // Opposite-signed operands where the result sign differs from Ain.
        alu_v   = (ain[15] != bin[15]) && (alu_res[15] != ain[15]);
      end
      AluAnd: alu_res = ain & bin;
      AluNot: alu_res = ~bin;
      default: alu_res = 16'h0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state. All reads use pre-edge contents, so a write and a
  // load of the same register in one cycle hands the old value to A/B, and
  // loadc with vsel=C writes back the old C.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 16'h0000;
      end
      a_q <= 16'h0000;
      b_q <= 16'h0000;
      c_q <= 16'h0000;
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      if (wr_en) begin
        rf_q[reg_idx] <= wdata;
      end
      if (loada) begin
        a_q <= rf_q[reg_idx];
      end
      if (loadb) begin
        b_q <= rf_q[reg_idx];
      end
      if (loadc) begin
        c_q <= alu_res;
      end
      if (loads) begin
        z_q <= (alu_res == 16'h0000);
        n_q <= alu_res[15];
        v_q <= alu_v;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign datapath_out = c_q;
  assign Z_out        = z_q;
  assign N_out        = n_q;
  assign V_out        = v_q;
  assign dbg_data     = rf_q[dbg_sel];

endmodule

// File: tb/tb_datapath_exec.sv
module tb_datapath_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic [2:0]  nsel;
  logic [3:0]  vsel;
  logic [15:0] mdata;
  logic [7:0]  pc_in;
  logic        write, loada, loadb;
  logic [1:0]  shift;
  logic        asel, bsel, loadc, loads;
  logic [15:0] datapath_out;
  logic        z_out, n_out, v_out;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_err    = 0;

  datapath_exec #(.PC_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .nsel         (nsel),
    .vsel         (vsel),
    .mdata        (mdata),
    .PC           (pc_in),
    .write        (write),
    .loada        (loada),
    .loadb        (loadb),
    .shift        (shift),
    .asel         (asel),
    .bsel         (bsel),
    .loadc        (loadc),
    .loads        (loads),
    .datapath_out (datapath_out),
    .Z_out        (z_out),
    .N_out        (n_out),
    .V_out        (v_out),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; instr = 16'h0; nsel = 3'b0; vsel = 4'b0; mdata = 16'h0; pc_in = 8'h0;
    write = 1'b0; loada = 1'b0; loadb = 1'b0; shift = 2'b0;
    asel = 1'b0; bsel = 1'b0; loadc = 1'b0; loads = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: one row = one clock, expectations sampled after the edge
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic        rst;
    logic [15:0] instr;
    logic [2:0]  nsel;
    logic [3:0]  vsel;
    logic        wr, la, lb;
    logic [1:0]  sh;
    logic        as, bs, lc, ls;
    logic [15:0] md;
    logic [7:0]  pc;
    logic [2:0]  dsel;
    logic [15:0] e_out;
    logic        e_z, e_n, e_v;
    logic [15:0] e_dbg;
  } vec_t;

  vec_t vecs[$];

  task automatic apply(input vec_t v);
    reset = v.rst; instr = v.instr; nsel = v.nsel; vsel = v.vsel;
    write = v.wr; loada = v.la; loadb = v.lb; shift = v.sh;
    asel = v.as; bsel = v.bs; loadc = v.lc; loads = v.ls;
    mdata = v.md; pc_in = v.pc; dbg_sel = v.dsel;
    tick();
    chk({v.name, ".out"}, datapath_out, v.e_out);
    chk({v.name, ".z"}, 16'(z_out), 16'(v.e_z));
    chk({v.name, ".n"}, 16'(n_out), 16'(v.e_n));
    chk({v.name, ".v"}, 16'(v_out), 16'(v.e_v));
    chk({v.name, ".dbg"}, dbg_data, v.e_dbg);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: architectural state and plain integer arithmetic
  // ---------------------------------------------------------------------------
  int unsigned m_r[8];
  int unsigned m_a, m_b, m_c;
  bit          m_z, m_n, m_v;
  int unsigned x_r[8];
  int unsigned x_a, x_b, x_c;
  bit          x_z, x_n, x_v;

  function automatic int to_signed(input int unsigned u);
    return (u >= 32768) ? int'(u) - 65536 : int'(u);
  endfunction

  function automatic int unsigned sext(input int unsigned val, input int unsigned bits);
    int unsigned half;
    half = 1 << (bits - 1);
    return (val >= half) ? val + 65536 - 2 * half : val;
  endfunction

  task automatic model_reset();
    foreach (m_r[i]) m_r[i] = 0;
    m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
  endtask

  task automatic model_next();
    int unsigned idx, bsh, ain, bin, res, wd;
    int          sres;
    bit          ov;
    x_r = m_r; x_a = m_a; x_b = m_b; x_c = m_c; x_z = m_z; x_n = m_n; x_v = m_v;
    if (reset) begin
      foreach (x_r[i]) x_r[i] = 0;
      x_a = 0; x_b = 0; x_c = 0; x_z = 0; x_n = 0; x_v = 0;
      return;
    end
    idx = 0;
    if (nsel == 3'b100) idx = instr[10:8];
    else if (nsel == 3'b010) idx = instr[7:5];
    else if (nsel == 3'b001) idx = instr[2:0];
    case (shift)
      2'd0: bsh = m_b;
      2'd1: bsh = (m_b * 2) % 65536;
      2'd2: bsh = m_b / 2;
      default: bsh = m_b / 2 + ((m_b >= 32768) ? 32768 : 0);
    endcase
    ain = asel ? 0 : m_a;
    bin = bsel ? sext(instr[4:0], 5) : bsh;
    ov = 0;
    case (instr[12:11])
      2'd0: begin
        res = (ain + bin) % 65536;
        sres = to_signed(ain) + to_signed(bin);
        ov = (sres > 32767) || (sres < -32768);
      end
      2'd1: begin
        res = (ain + 65536 - bin) % 65536;
        sres = to_signed(ain) - to_signed(bin);
        ov = (sres > 32767) || (sres < -32768);
      end
      2'd2: res = ain & bin;
      default: res = 65535 - bin;
    endcase
    wd = 0;
    case (vsel)
      4'b1000: wd = mdata;
      4'b0100: wd = sext(instr[7:0], 8);
      4'b0010: wd = pc_in;
      4'b0001: wd = m_c;
      default: wd = 0;
    endcase
    if (write && $countones(nsel) == 1 && $countones(vsel) == 1) x_r[idx] = wd;
    if (loada) x_a = m_r[idx];
    if (loadb) x_b = m_r[idx];
    if (loadc) x_c = res;
    if (loads) begin
      x_z = (res == 0);
      x_n = (res >= 32768);
      x_v = ov;
    end
  endtask

  task automatic model_commit();
    m_r = x_r; m_a = x_a; m_b = x_b; m_c = x_c; m_z = x_z; m_n = x_n; m_v = x_v;
  endtask

  function automatic logic [2:0] pick_nsel();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 3) return 3'b100;
    if (r < 6) return 3'b010;
    if (r < 8) return 3'b001;
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic [3:0] pick_vsel();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 8) return 4'b0001 << (r % 4);
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    idle();
    dbg_sel = 3'd0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Reset clears a populated datapath
    for (int i = 0; i < 8; i++) begin
      instr = {5'b0, 3'(i), 8'h81 + 8'(i)};
      nsel = 3'b100; vsel = 4'b0100; write = 1'b1;
      tick();
    end
    idle();
    instr = 16'h0100; nsel = 3'b100; loada = 1'b1; loadb = 1'b1;
    tick();
    idle();
    instr = 16'h0000; loadc = 1'b1; loads = 1'b1;
    tick();
    chk("pre_reset.out", datapath_out, 16'hFF04);
    idle();
    reset = 1'b1; write = 1'b1; nsel = 3'b100; vsel = 4'b0100; instr = 16'h0177;
    loadc = 1'b1; loads = 1'b1; loada = 1'b1;
    tick();
    idle();
    chk("reset.out", datapath_out, 16'h0000);
    chk("reset.z", 16'(z_out), 16'h0);
    chk("reset.n", 16'(n_out), 16'h0);
    chk("reset.v", 16'(v_out), 16'h0);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      chk($sformatf("reset.r%0d", i), dbg_data, 16'h0000);
    end
    // A and B cleared: A+B lands in C as 0 and sets Z
    loadc = 1'b1; loads = 1'b1;
    tick();
    idle();
    chk("reset.ab_sum", datapath_out, 16'h0000);
    chk("reset.ab_z", 16'(z_out), 16'h1);

    // Directed table
    vecs.push_back('{"mov_imm_r3", 0, 16'h03F6, 3'b100, 4'b0100, 1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd3, 16'h0000, 1, 0, 0, 16'hFFF6});
    vecs.push_back('{"pc_r4",      0, 16'h0400, 3'b100, 4'b0010, 1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h2A, 3'd4, 16'h0000, 1, 0, 0, 16'h002A});
    vecs.push_back('{"mov_r1",     0, 16'h0107, 3'b100, 4'b0100, 1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd1, 16'h0000, 1, 0, 0, 16'h0007});
    vecs.push_back('{"mov_r2",     0, 16'h0203, 3'b100, 4'b0100, 1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd2, 16'h0000, 1, 0, 0, 16'h0003});
    vecs.push_back('{"loada_r1",   0, 16'h01A2, 3'b100, 4'b0000, 0, 1, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd1, 16'h0000, 1, 0, 0, 16'h0007});
    vecs.push_back('{"loadb_r2",   0, 16'h01A2, 3'b001, 4'b0000, 0, 0, 1, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd2, 16'h0000, 1, 0, 0, 16'h0003});
    vecs.push_back('{"add_lsl",    0, 16'h01A2, 3'b000, 4'b0000, 0, 0, 0, 2'b01, 0, 0, 1, 1, 16'h0, 8'h00, 3'd5, 16'h000D, 0, 0, 0, 16'h0000});
    vecs.push_back('{"wb_r5",      0, 16'h01A2, 3'b010, 4'b0001, 1, 0, 0, 2'b01, 0, 0, 0, 0, 16'h0, 8'h00, 3'd5, 16'h000D, 0, 0, 0, 16'h000D});
    vecs.push_back('{"mdata_r6",   0, 16'h0600, 3'b100, 4'b1000, 1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h8000, 8'h00, 3'd6, 16'h000D, 0, 0, 0, 16'h8000});
    vecs.push_back('{"mov_r7",     0, 16'h0701, 3'b100, 4'b0100, 1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd7, 16'h000D, 0, 0, 0, 16'h0001});
    vecs.push_back('{"loada_r6",   0, 16'h0E07, 3'b100, 4'b0000, 0, 1, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd6, 16'h000D, 0, 0, 0, 16'h8000});
    vecs.push_back('{"loadb_r7",   0, 16'h0E07, 3'b001, 4'b0000, 0, 0, 1, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd7, 16'h000D, 0, 0, 0, 16'h0001});
    vecs.push_back('{"sub_ovf",    0, 16'h0E07, 3'b000, 4'b0000, 0, 0, 0, 2'b00, 0, 0, 1, 1, 16'h0, 8'h00, 3'd7, 16'h7FFF, 0, 0, 1, 16'h0001});
    vecs.push_back('{"mov_r3_5",   0, 16'h0305, 3'b100, 4'b0100, 1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd3, 16'h7FFF, 0, 0, 1, 16'h0005});
    vecs.push_back('{"ld_ab_r3",   0, 16'h0B03, 3'b100, 4'b0000, 0, 1, 1, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd3, 16'h7FFF, 0, 0, 1, 16'h0005});
    vecs.push_back('{"sub_zero",   0, 16'h0B03, 3'b000, 4'b0000, 0, 0, 0, 2'b00, 0, 0, 1, 1, 16'h0, 8'h00, 3'd3, 16'h0000, 1, 0, 0, 16'h0005});
    vecs.push_back('{"mdata_r2",   0, 16'h0200, 3'b100, 4'b1000, 1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h8002, 8'h00, 3'd2, 16'h0000, 1, 0, 0, 16'h8002});
    vecs.push_back('{"loadb_8002", 0, 16'h1802, 3'b001, 4'b0000, 0, 0, 1, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd2, 16'h0000, 1, 0, 0, 16'h8002});
    vecs.push_back('{"not_lsr",    0, 16'h1802, 3'b000, 4'b0000, 0, 0, 0, 2'b10, 0, 0, 1, 1, 16'h0, 8'h00, 3'd2, 16'hBFFE, 0, 1, 0, 16'h8002});
    vecs.push_back('{"not_asr",    0, 16'h1802, 3'b000, 4'b0000, 0, 0, 0, 2'b11, 0, 0, 1, 1, 16'h0, 8'h00, 3'd2, 16'h3FFE, 0, 0, 0, 16'h8002});
    vecs.push_back('{"imm5_asel",  0, 16'h0010, 3'b000, 4'b0000, 0, 0, 0, 2'b00, 1, 1, 1, 1, 16'h0, 8'h00, 3'd0, 16'hFFF0, 0, 1, 0, 16'h0000});
    vecs.push_back('{"loads_only", 0, 16'h0000, 3'b000, 4'b0000, 0, 0, 0, 2'b00, 1, 1, 0, 1, 16'h0, 8'h00, 3'd0, 16'hFFF0, 1, 0, 0, 16'h0000});
    vecs.push_back('{"loadc_only", 0, 16'h0001, 3'b000, 4'b0000, 0, 0, 0, 2'b00, 1, 1, 1, 0, 16'h0, 8'h00, 3'd0, 16'h0001, 1, 0, 0, 16'h0000});
    vecs.push_back('{"wr_loada",   0, 16'h0155, 3'b100, 4'b0100, 1, 1, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd1, 16'h0001, 1, 0, 0, 16'h0055});
    vecs.push_back('{"a_old",      0, 16'h0000, 3'b000, 4'b0000, 0, 0, 0, 2'b00, 0, 1, 1, 0, 16'h0, 8'h00, 3'd1, 16'h0007, 1, 0, 0, 16'h0055});
    vecs.push_back('{"bad_nsel",   0, 16'h0133, 3'b011, 4'b0100, 1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd1, 16'h0007, 1, 0, 0, 16'h0055});
    vecs.push_back('{"bad_nsel_r0",0, 16'h0133, 3'b011, 4'b0100, 1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd0, 16'h0007, 1, 0, 0, 16'h0000});
    vecs.push_back('{"vsel_zero",  0, 16'h0133, 3'b100, 4'b0000, 1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd1, 16'h0007, 1, 0, 0, 16'h0055});
    vecs.push_back('{"vsel_multi", 0, 16'h0133, 3'b100, 4'b0110, 1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd1, 16'h0007, 1, 0, 0, 16'h0055});
    vecs.push_back('{"nsel_none",  0, 16'h0100, 3'b000, 4'b0000, 0, 1, 0, 2'b00, 0, 0, 0, 0, 16'h0, 8'h00, 3'd1, 16'h0007, 1, 0, 0, 16'h0055});
    vecs.push_back('{"a_is_r0",    0, 16'h0003, 3'b000, 4'b0000, 0, 0, 0, 2'b00, 0, 1, 1, 0, 16'h0, 8'h00, 3'd1, 16'h0003, 1, 0, 0, 16'h0055});
    vecs.push_back('{"wb_old_c",   0, 16'h0105, 3'b100, 4'b0001, 1, 0, 0, 2'b00, 1, 1, 1, 0, 16'h0, 8'h00, 3'd1, 16'h0005, 1, 0, 0, 16'h0003});
    vecs.push_back('{"reset_mid",  1, 16'h0105, 3'b100, 4'b0100, 1, 1, 1, 2'b00, 1, 1, 1, 1, 16'h0, 8'h00, 3'd1, 16'h0000, 0, 0, 0, 16'h0000});
    foreach (vecs[i]) apply(vecs[i]);
    idle();

    // Randomized run against the reference model
    reset = 1'b1;
    tick();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      instr = 16'($urandom);
      nsel  = pick_nsel();
      vsel  = pick_vsel();
      mdata = 16'($urandom);
      pc_in = 8'($urandom);
      write = $urandom_range(0, 1) == 1;
      loada = $urandom_range(0, 2) == 0;
      loadb = $urandom_range(0, 2) == 0;
      shift = 2'($urandom_range(0, 3));
      asel  = $urandom_range(0, 3) == 0;
      bsel  = $urandom_range(0, 3) == 0;
      loadc = $urandom_range(0, 1) == 1;
      loads = $urandom_range(0, 1) == 1;
      dbg_sel = 3'($urandom_range(0, 7));
      model_next();
      tick();
      model_commit();
      chk($sformatf("rnd%0d.out", c), datapath_out, 16'(m_c));
      chk($sformatf("rnd%0d.z", c), 16'(z_out), 16'(m_z));
      chk($sformatf("rnd%0d.n", c), 16'(n_out), 16'(m_n));
      chk($sformatf("rnd%0d.v", c), 16'(v_out), 16'(m_v));
      chk($sformatf("rnd%0d.dbg", c), dbg_data, 16'(m_r[dbg_sel]));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
